// File: rtl/param_combolock_pkg.sv
// Shared definitions for the parameterised combination lock: state
// encoding, state width and width helpers used by the lock and its bench.
package combolock_pkg;

   localparam int STATE_W = 3;

   typedef enum logic [STATE_W-1:0] {
      LOCKED     = 3'd0,
      OPEN       = 3'd1,
      NEW_ENTRY  = 3'd2,
      NEW_VERIFY = 3'd3,
      ALARM      = 3'd4
   } state_t;

   // Width of the tries-left / fail-count field: must hold 0..max_tries.
   function automatic int tries_width(input int max_tries);
      return (max_tries < 1) ? 1 : $clog2(max_tries + 1);
   endfunction

   // Width of the lockout timer: must hold 0..cycles, never narrower than 1.
   function automatic int timer_width(input int cycles);
      return (cycles < 1) ? 1 : $clog2(cycles + 1);
   endfunction

endpackage

// File: rtl/param_combolock_if.sv
// User-side bundle of the combination lock: code/button inputs and the
// status outputs. The lock itself connects through the slave modport.
interface param_combolock_if #(
   parameter int CODE_W  = 4,
   parameter int TRIES_W = 2
);
   import combolock_pkg::*;

   logic [CODE_W-1:0]  code;
   logic               confirm;
   logic               change;
   logic [STATE_W-1:0] state;
   logic               unlocked;
   logic               alarm;
   logic [TRIES_W-1:0] tries_left;
   logic               code_updated;

   modport master (
      output code, confirm, change,
      input  state, unlocked, alarm, tries_left, code_updated
   );

   modport slave (
      input  code, confirm, change,
      output state, unlocked, alarm, tries_left, code_updated
   );

endinterface

// File: rtl/param_combolock_edge_pulse.sv
// Rising-edge detector for a raw button level. The pulse is high in the
// cycle where the level is 1 but was 0 at the previous clock edge, so it
// acts at the very next edge. History resets to 1 so a button held
// through reset never produces a pulse.
module edge_pulse (
   input  logic Clock,
   input  logic Reset,
   input  logic level,
   output logic pulse
);

   logic hist_r;

   // Remember the level seen at the last rising edge.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         hist_r <= 1'b1;
      end else begin
         hist_r <= level;
      end
   end

   assign pulse = level & ~hist_r;

endmodule

// File: rtl/param_combolock.sv
// Parameterised combination lock. Buttons are edge-detected, Confirm wins
// over Change when both rise together. A run of MAX_TRIES wrong Confirm
// attempts raises ALARM for LOCKOUT_CYCLES clocks (forever when 0).
// The stored code can be replaced by an entry/verify sequence.
module param_combolock
   import combolock_pkg::*;
#(
   parameter int                CODE_W         = 4,
   parameter logic [CODE_W-1:0] INIT_CODE      = CODE_W'(4'b0110),
   parameter int                MAX_TRIES      = 2,
   parameter int                LOCKOUT_CYCLES = 16
) (
   input logic              Clock,
   input logic              Reset,
   param_combolock_if.slave bus
);

   localparam int                 TRIES_W    = tries_width(MAX_TRIES);
   localparam int                 TIMER_W    = timer_width(LOCKOUT_CYCLES);
   localparam logic [TRIES_W-1:0] TRIES_MAX  = TRIES_W'(MAX_TRIES);
   localparam logic [TRIES_W-1:0] TRIES_ONE  = TRIES_W'(1'b1);
   localparam logic [TIMER_W-1:0] TIMER_LOAD = TIMER_W'(LOCKOUT_CYCLES);
   localparam logic [TIMER_W-1:0] TIMER_ONE  = TIMER_W'(1'b1);
   localparam bit                 STICKY     = (LOCKOUT_CYCLES == 0);

   // button pulses
   logic conf_p_s;
   logic chg_raw_s;
   logic chg_p_s;
   logic any_p_s;

   // code comparisons and saturating fail increment
   logic               code_hit_s;
   logic               verify_hit_s;
   logic [TRIES_W-1:0] fail_inc_s;

   // architectural state and next-state
   state_t             state_r,   state_nx;
   logic [CODE_W-1:0]  stored_r,  stored_nx;
   logic [CODE_W-1:0]  pending_r, pending_nx;
   logic [TRIES_W-1:0] fail_r,    fail_nx;
   logic [TIMER_W-1:0] timer_r,   timer_nx;
   logic               upd_nx;

   // registered outputs
   logic               upd_r;
   logic               unlocked_r;
   logic               alarm_r;
   logic [TRIES_W-1:0] tries_left_r;

   edge_pulse u_conf_edge (
      .Clock (Clock),
      .Reset (Reset),
      .level (bus.confirm),
      .pulse (conf_p_s)
   );

   edge_pulse u_chg_edge (
      .Clock (Clock),
      .Reset (Reset),
      .level (bus.change),
      .pulse (chg_raw_s)
   );

   // Confirm has priority: a simultaneous Change pulse is dropped.
   assign chg_p_s      = chg_raw_s & ~conf_p_s;
   assign any_p_s      = conf_p_s | chg_raw_s;
   assign code_hit_s   = (bus.code == stored_r);
   assign verify_hit_s = (bus.code == pending_r);
   assign fail_inc_s   = (fail_r >= TRIES_MAX) ? TRIES_MAX : (fail_r + TRIES_ONE);

   // Next-state and datapath decisions for every lock state.
   always_comb begin
      state_nx   = state_r;
      stored_nx  = stored_r;
      pending_nx = pending_r;
      fail_nx    = fail_r;
      timer_nx   = timer_r;
      upd_nx     = 1'b0;

      case (state_r)
         LOCKED: begin
            if (conf_p_s) begin
               if (code_hit_s) begin
                  state_nx = OPEN;
                  fail_nx  = '0;
               end else if (fail_inc_s >= TRIES_MAX) begin
                  state_nx = ALARM;
                  fail_nx  = '0;
                  timer_nx = TIMER_LOAD;
               end else begin
                  fail_nx  = fail_inc_s;
               end
            end else if (chg_p_s) begin
               if (code_hit_s) begin
                  state_nx = NEW_ENTRY;
               end else begin
                  state_nx = LOCKED;
               end
            end else begin
               state_nx = LOCKED;
            end
         end

         OPEN: begin
            if (conf_p_s) begin
               state_nx = LOCKED;
            end else if (chg_p_s) begin
               state_nx = NEW_ENTRY;
            end else begin
               state_nx = OPEN;
            end
         end

         NEW_ENTRY: begin
            if (any_p_s) begin
               pending_nx = bus.code;
               state_nx   = NEW_VERIFY;
            end else begin
               state_nx   = NEW_ENTRY;
            end
         end

         NEW_VERIFY: begin
            if (any_p_s) begin
               state_nx = LOCKED;
               if (verify_hit_s) begin
                  stored_nx = pending_r;
                  upd_nx    = 1'b1;
               end else begin
                  stored_nx = stored_r;
               end
            end else begin
               state_nx = NEW_VERIFY;
            end
         end

         ALARM: begin
            // Buttons are ignored; a zero lockout keeps the alarm until reset.
            if (STICKY) begin
               state_nx = ALARM;
            end else if (timer_r <= TIMER_ONE) begin
               state_nx = LOCKED;
               timer_nx = '0;
            end else begin
               timer_nx = timer_r - TIMER_ONE;
            end
         end

         default: begin
            state_nx = LOCKED;
            fail_nx  = '0;
            timer_nx = '0;
         end
      endcase
   end

   // State, code storage and output registers; reset restores the factory code.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state_r      <= LOCKED;
         stored_r     <= INIT_CODE;
         pending_r    <= '0;
         fail_r       <= '0;
         timer_r      <= '0;
         upd_r        <= 1'b0;
         unlocked_r   <= 1'b0;
         alarm_r      <= 1'b0;
         tries_left_r <= TRIES_MAX;
      end else begin
         state_r      <= state_nx;
         stored_r     <= stored_nx;
         pending_r    <= pending_nx;
         fail_r       <= fail_nx;
         timer_r      <= timer_nx;
         upd_r        <= upd_nx;
         unlocked_r   <= (state_nx == OPEN);
         alarm_r      <= (state_nx == ALARM);
         tries_left_r <= TRIES_MAX - fail_nx;
      end
   end

   assign bus.state        = state_r;
   assign bus.unlocked     = unlocked_r;
   assign bus.alarm        = alarm_r;
   assign bus.tries_left   = tries_left_r;
   assign bus.code_updated = upd_r;

endmodule

// File: tb/tb_param_combolock.sv
// Self-checking bench for param_combolock. A behavioural model of the lock
// rules is stepped on every rising edge and compared against the DUT on
// every falling edge; directed sequences add literal expectations. A second
// instance with a zero lockout exercises the sticky alarm.
module tb_param_combolock;
   import combolock_pkg::*;

   localparam int MAX_TRIES = 2;
   localparam int LOCKOUT   = 16;
   localparam int TRIES_W   = tries_width(MAX_TRIES);

   localparam int S_LOCKED     = 0;
   localparam int S_OPEN       = 1;
   localparam int S_NEW_ENTRY  = 2;
   localparam int S_NEW_VERIFY = 3;
   localparam int S_ALARM      = 4;

   logic Clock  = 1'b0;
   logic Reset  = 1'b0;
   logic Reset0 = 1'b1;
   bit   cmp_en = 1'b0;
   int   checks = 0;
   int   errors = 0;
   int   cnt;
   int   held;

   always #5 Clock = ~Clock;

   param_combolock_if #(.CODE_W(4), .TRIES_W(TRIES_W)) bus  ();
   param_combolock_if #(.CODE_W(4), .TRIES_W(TRIES_W)) bus0 ();

   param_combolock #(
      .CODE_W(4), .INIT_CODE(4'b0110), .MAX_TRIES(MAX_TRIES), .LOCKOUT_CYCLES(LOCKOUT)
   ) dut (
      .Clock(Clock), .Reset(Reset), .bus(bus)
   );

   param_combolock #(
      .CODE_W(4), .INIT_CODE(4'b0110), .MAX_TRIES(MAX_TRIES), .LOCKOUT_CYCLES(0)
   ) dut0 (
      .Clock(Clock), .Reset(Reset0), .bus(bus0)
   );

   // ---------------- behavioural model ----------------
   typedef struct {
      int         st;
      int         fails;
      int         left;
      logic [3:0] stored;
      logic [3:0] pending;
      bit         upd;
      bit         pc;
      bit         pg;
   } model_t;

   model_t m;

   function automatic model_t model_reset();
      model_t r;
      r.st = S_LOCKED; r.fails = 0; r.left = 0;
      r.stored = 4'b0110; r.pending = 4'b0000;
      r.upd = 1'b0; r.pc = 1'b1; r.pg = 1'b1;
      return r;
   endfunction

   function automatic model_t model_step(input model_t s, input logic [3:0] code,
                                         input logic conf, input logic chg);
      model_t n;
      bit cp, gp, hit;
      n = s;
      cp = conf && !s.pc;
      gp = chg && !s.pg && !cp;
      n.pc = conf;
      n.pg = chg;
      n.upd = 1'b0;
      hit = (code == s.stored);
      if (s.st == S_ALARM) begin
         if (LOCKOUT != 0) begin
            n.left = s.left - 1;
            if (n.left == 0) n.st = S_LOCKED;
         end
      end else if (cp || gp) begin
         case (s.st)
            S_LOCKED: begin
               if (cp) begin
                  if (hit) begin
                     n.st = S_OPEN; n.fails = 0;
                  end else begin
                     n.fails = s.fails + 1;
                     if (n.fails >= MAX_TRIES) begin
                        n.st = S_ALARM; n.fails = 0; n.left = LOCKOUT;
                     end
                  end
               end else if (hit) begin
                  n.st = S_NEW_ENTRY;
               end
            end
            S_OPEN:      n.st = cp ? S_LOCKED : S_NEW_ENTRY;
            S_NEW_ENTRY: begin n.pending = code; n.st = S_NEW_VERIFY; end
            S_NEW_VERIFY: begin
               if (code == s.pending) begin n.stored = s.pending; n.upd = 1'b1; end
               n.st = S_LOCKED;
            end
            default:     n.st = S_LOCKED;
         endcase
      end
      return n;
   endfunction

   always @(posedge Clock or posedge Reset) begin
      if (Reset) m <= model_reset();
      else       m <= model_step(m, bus.code, bus.confirm, bus.change);
   end

   // ---------------- checking ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge Clock) begin
      if (cmp_en) begin
         check("cyc_state",    32'(bus.state),        m.st);
         check("cyc_unlocked", 32'(bus.unlocked),     (m.st == S_OPEN)  ? 1 : 0);
         check("cyc_alarm",    32'(bus.alarm),        (m.st == S_ALARM) ? 1 : 0);
         check("cyc_tries",    32'(bus.tries_left),   MAX_TRIES - m.fails);
         check("cyc_updated",  32'(bus.code_updated), m.upd ? 1 : 0);
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic press(input logic [3:0] c, input logic conf, input logic chg);
      bus.code = c; bus.confirm = conf; bus.change = chg;
      @(negedge Clock);
      bus.confirm = 1'b0; bus.change = 1'b0;
      @(negedge Clock);
   endtask

   task automatic press0(input logic [3:0] c);
      bus0.code = c; bus0.confirm = 1'b1;
      @(negedge Clock);
      bus0.confirm = 1'b0;
      @(negedge Clock);
   endtask

   task automatic async_reset();
      #2 Reset = 1'b1;
      #1 check("rst_async_state", 32'(bus.state), S_LOCKED);
      check("rst_async_alarm", 32'(bus.alarm), 0);
      @(negedge Clock);
      Reset = 1'b0;
      @(negedge Clock);
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      bus.code = 4'd0;  bus.confirm = 1'b0;  bus.change = 1'b0;
      bus0.code = 4'd0; bus0.confirm = 1'b0; bus0.change = 1'b0;
      #1 Reset = 1'b1;
      cmp_en = 1'b1;
      repeat (3) @(negedge Clock);
      check("reset_state",    32'(bus.state), S_LOCKED);
      check("reset_tries",    32'(bus.tries_left), 2);
      check("reset_unlocked", 32'(bus.unlocked), 0);
      check("reset_alarm",    32'(bus.alarm), 0);
      check("reset_updated",  32'(bus.code_updated), 0);
      Reset = 1'b0;
      @(negedge Clock);

      // open with the factory code, then lock again
      press(4'b0110, 1'b1, 1'b0);
      check("open_state", 32'(bus.state), S_OPEN);
      check("open_unlocked", 32'(bus.unlocked), 1);
      press(4'b0110, 1'b1, 1'b0);
      check("relock_state", 32'(bus.state), S_LOCKED);

      // two wrong attempts -> alarm for exactly 16 cycles, presses ignored
      press(4'b0001, 1'b1, 1'b0);
      check("fail1_tries", 32'(bus.tries_left), 1);
      bus.code = 4'b0001; bus.confirm = 1'b1;
      cnt = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge Clock);
         if (i == 0) bus.confirm = 1'b0;
         if (i == 4) begin bus.code = 4'b0110; bus.confirm = 1'b1; end
         if (i == 6) bus.confirm = 1'b0;
         if (bus.alarm === 1'b1) cnt++;
      end
      check("alarm_cycles", 32'(cnt), 16);
      check("alarm_exit_state", 32'(bus.state), S_LOCKED);
      check("alarm_exit_tries", 32'(bus.tries_left), 2);

      // change code to 1010
      press(4'b0110, 1'b0, 1'b1);
      check("entry_state", 32'(bus.state), S_NEW_ENTRY);
      press(4'b1010, 1'b1, 1'b0);
      check("verify_state", 32'(bus.state), S_NEW_VERIFY);
      bus.code = 4'b1010; bus.confirm = 1'b1;
      @(negedge Clock);
      check("update_state", 32'(bus.state), S_LOCKED);
      check("update_pulse", 32'(bus.code_updated), 1);
      bus.confirm = 1'b0;
      @(negedge Clock);
      check("update_pulse_end", 32'(bus.code_updated), 0);
      press(4'b1010, 1'b1, 1'b0);
      check("new_code_opens", 32'(bus.state), S_OPEN);
      press(4'b1010, 1'b1, 1'b0);
      press(4'b0110, 1'b1, 1'b0);
      check("old_code_fails", 32'(bus.state), S_LOCKED);
      check("old_code_tries", 32'(bus.tries_left), 1);
      press(4'b1010, 1'b1, 1'b0);
      check("open_clears_fails", 32'(bus.tries_left), 2);

      // from OPEN, Change enters a new code; verify mismatch keeps 1010
      press(4'b0000, 1'b0, 1'b1);
      check("open_change_state", 32'(bus.state), S_NEW_ENTRY);
      press(4'b0011, 1'b0, 1'b1);
      press(4'b0101, 1'b0, 1'b1);
      check("verify_miss_state", 32'(bus.state), S_LOCKED);
      press(4'b1010, 1'b1, 1'b0);
      check("kept_code_opens", 32'(bus.state), S_OPEN);
      press(4'b1010, 1'b1, 1'b0);

      // reset restores 0110; verify mismatch 1011
      async_reset();
      press(4'b0110, 1'b0, 1'b1);
      press(4'b1100, 1'b1, 1'b0);
      press(4'b1011, 1'b1, 1'b0);
      check("mismatch_locked", 32'(bus.state), S_LOCKED);
      press(4'b0110, 1'b1, 1'b0);
      check("init_still_opens", 32'(bus.state), S_OPEN);
      press(4'b0110, 1'b1, 1'b0);
      press(4'b0011, 1'b0, 1'b1);
      check("bad_change_ignored", 32'(bus.state), S_LOCKED);
      press(4'b0110, 1'b1, 1'b1);
      check("confirm_priority", 32'(bus.state), S_OPEN);
      press(4'b0110, 1'b1, 1'b0);
      press(4'b0000, 1'b1, 1'b0);
      press(4'b0000, 1'b0, 1'b1);
      check("bad_change_keeps_fails", 32'(bus.tries_left), 1);
      press(4'b0110, 1'b1, 1'b0);
      press(4'b0110, 1'b1, 1'b0);

      // Confirm held across reset release: no transition
      #2 Reset = 1'b1;
      bus.code = 4'b0110; bus.confirm = 1'b1;
      repeat (2) @(negedge Clock);
      Reset = 1'b0;
      repeat (3) @(negedge Clock);
      check("held_confirm_state", 32'(bus.state), S_LOCKED);
      check("held_confirm_unlocked", 32'(bus.unlocked), 0);
      bus.confirm = 1'b0;
      @(negedge Clock);

      // reset during NEW_VERIFY discards the pending code
      press(4'b0110, 1'b0, 1'b1);
      press(4'b1111, 1'b1, 1'b0);
      check("pre_reset_verify", 32'(bus.state), S_NEW_VERIFY);
      async_reset();
      press(4'b1111, 1'b1, 1'b0);
      check("pending_discarded", 32'(bus.state), S_LOCKED);
      press(4'b0110, 1'b1, 1'b0);
      check("init_after_verify_rst", 32'(bus.state), S_OPEN);
      press(4'b0110, 1'b1, 1'b0);

      // store 1001, go to ALARM, reset: factory code works again
      press(4'b0110, 1'b0, 1'b1);
      press(4'b1001, 1'b1, 1'b0);
      press(4'b1001, 1'b1, 1'b0);
      press(4'b0000, 1'b1, 1'b0);
      press(4'b0000, 1'b1, 1'b0);
      check("pre_reset_alarm", 32'(bus.alarm), 1);
      repeat (3) @(negedge Clock);
      async_reset();
      press(4'b0110, 1'b1, 1'b0);
      check("init_after_alarm_rst", 32'(bus.state), S_OPEN);
      press(4'b0110, 1'b1, 1'b0);

      // zero lockout: alarm is sticky until reset
      Reset0 = 1'b0;
      @(negedge Clock);
      check("lk0_reset_state", 32'(bus0.state), S_LOCKED);
      press0(4'b0001);
      press0(4'b0010);
      check("lk0_enter_alarm", 32'(bus0.alarm), 1);
      held = 0;
      for (int i = 0; i < 1000; i++) begin
         if (i == 100) begin bus0.code = 4'b0110; bus0.confirm = 1'b1; end
         if (i == 102) bus0.confirm = 1'b0;
         @(negedge Clock);
         if (bus0.alarm === 1'b1 && bus0.state === 3'd4) held++;
      end
      check("lk0_alarm_held", 32'(held), 1000);
      #2 Reset0 = 1'b1;
      #1 check("lk0_reset_clear", 32'(bus0.state), S_LOCKED);
      check("lk0_reset_alarm", 32'(bus0.alarm), 0);
      @(negedge Clock);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/param_combolock.md
PARAM_COMBOLOCK -- requirements
Module: param_combolock

Interface
REQ-001 Parameter CODE_W, default 4, code width in bits (>=1).
REQ-002 Parameter INIT_CODE, default 6 (4'b0110), code loaded at reset, CODE_W bits.
REQ-003 Parameter MAX_TRIES, default 2, wrong Confirm attempts allowed before ALARM (>=1).
REQ-004 Parameter LOCKOUT_CYCLES, default 16, ALARM duration in clocks; 0 = ALARM sticky until reset.
REQ-005 Clock  input  1  single clock; all state on rising edge.
REQ-006 Reset  input  1  asynchronous, active-high reset.
REQ-007 Code  input  CODE_W  user-entered code, sampled at rising Clock edges.
REQ-008 Confirm  input  1  raw level button, edge-detected internally.
REQ-009 Change  input  1  raw level button, edge-detected internally.
REQ-010 State  output  3  current FSM state encoding.
REQ-011 Unlocked  output  1  high iff State==OPEN.
REQ-012 Alarm  output  1  high iff State==ALARM.
REQ-013 TriesLeft  output  $clog2(MAX_TRIES+1)  MAX_TRIES minus fail count.
REQ-014 CodeUpdated  output  1  one-cycle pulse when stored code is replaced.

Function
REQ-015 conf_p/chg_p SHALL be high in the cycle input is 1 and was 0 at previous edge; acts at that same edge (zero-cycle latency); held level produces exactly one pulse.
REQ-016 States SHALL be LOCKED, OPEN, NEW_ENTRY, NEW_VERIFY, ALARM; all outputs registered or decoded from registered state only.
REQ-017 LOCKED: conf_p & Code==stored -> OPEN, fail count cleared.
REQ-018 LOCKED: conf_p & mismatch -> fail count +1; if result reaches MAX_TRIES -> ALARM, fail count cleared, timer loaded with LOCKOUT_CYCLES.
REQ-019 LOCKED: chg_p & Code==stored -> NEW_ENTRY; chg_p & mismatch ignored, fail count unchanged.
REQ-020 Simultaneous conf_p and chg_p in any state: conf_p has priority, chg_p discarded.
REQ-021 OPEN: conf_p -> LOCKED; chg_p -> NEW_ENTRY (no code check).
REQ-022 NEW_ENTRY: conf_p or chg_p -> capture Code into pending register, -> NEW_VERIFY.
REQ-023 NEW_VERIFY: conf_p or chg_p with Code==pending -> stored<=pending, CodeUpdated=1 next cycle, -> LOCKED; mismatch -> LOCKED, stored unchanged, no pulse.
REQ-024 ALARM: all pulses ignored; timer decrements each cycle; on timer==1 -> LOCKED next edge (exactly LOCKOUT_CYCLES cycles in ALARM); LOCKOUT_CYCLES==0 -> remain until reset.
REQ-025 Fail count SHALL saturate, never wrap; TriesLeft==MAX_TRIES except in LOCKED after failures.
REQ-026 Unused state encodings SHALL recover to LOCKED next edge.

Reset
REQ-027 On Reset: State=LOCKED, stored=INIT_CODE, pending=0, fail count=0, timer=0, CodeUpdated=0, Unlocked=0, Alarm=0, TriesLeft=MAX_TRIES.
REQ-028 Edge-detect history registers SHALL reset to 1, so buttons held through reset produce no pulse.
REQ-029 Reset asserted mid-operation (any state, incl. NEW_VERIFY or ALARM) SHALL discard pending code and restore INIT_CODE immediately, asynchronously.

Structure
REQ-030 State encoding (LOCKED=0, OPEN=1, NEW_ENTRY=2, NEW_VERIFY=3, ALARM=4) and width constant SHALL live in shared package combolock_pkg.
REQ-031 Edge detection SHALL be one sub-module edge_pulse (Clock, Reset, level in, pulse out), instantiated twice.

Verification
REQ-032 Reset, Code=0110, Confirm rise -> State=OPEN, Unlocked=1 same edge; Confirm rise again -> LOCKED.
REQ-033 MAX_TRIES=2: Code=0001 Confirm twice -> TriesLeft 2->1->ALARM; Alarm high exactly 16 cycles, then LOCKED, TriesLeft=2.
REQ-034 Change with 0110 -> NEW_ENTRY; Code=1010 Confirm -> NEW_VERIFY; 1010 Confirm -> LOCKED, CodeUpdated one-cycle pulse; 1010 now opens, 0110 fails.
REQ-035 NEW_VERIFY with mismatch 1011 -> LOCKED, 0110 still opens; Confirm and Change rising same cycle in LOCKED with 0110 -> OPEN.
REQ-036 Confirm held high across reset release -> no transition; Reset asserted in ALARM and NEW_VERIFY -> LOCKED, stored=INIT_CODE; LOCKOUT_CYCLES=0 -> ALARM held 1000 cycles.
